// File: rtl/system_bus_pkg.sv
// Shared types and widths for the CPU system bus arbiter.
package system_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        REQ_IFETCH = 1'b0,
        REQ_MEM    = 1'b1
    } requester_t;

endpackage

// File: rtl/read_owner_fifo.sv
// Circular FIFO of requester IDs, one entry per accepted-but-unreturned read.
module read_owner_fifo
    import system_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  requester_t               push_id,
    input  logic                     pop,
    output requester_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    requester_t       owner_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Status flags and guarded push/pop; a push at full is dropped even if a pop happens.
    always_comb begin
        full   = (count_r == CNT_FULL);
        empty  = (count_r == {CNT_W{1'b0}});
        push_s = push & ~full;
        pop_s  = pop & ~empty;
        head   = owner_mem_r[rd_ptr_r];
        count  = count_r;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Owner storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) owner_mem_r[i] <= REQ_IFETCH;
        end else if (push_s) begin
            owner_mem_r[wr_ptr_r] <= push_id;
        end
    end

endmodule

// File: rtl/system_bus_arbiter_checker.sv
// Protocol watch for the arbiter: a read return must always have an outstanding owner.
module system_bus_arbiter_checker #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset_n,
    input logic             read_data_valid,
    input logic [CNT_W-1:0] count
);

    property p_return_has_owner;
        @(posedge clk) disable iff (!reset_n)
            read_data_valid |-> (count != {CNT_W{1'b0}});
    endproperty

    a_return_has_owner: assert property (p_return_has_owner)
        else $warning("system_bus_arbiter: read return with no outstanding read");

endmodule

// File: rtl/system_bus_arbiter.sv
// Shares the CPU system bus between instruction fetch and load/store, round-robin on conflict,
// and steers each read return to the requester that issued it.
module system_bus_arbiter
    import system_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              ifetch_ready,
    input  logic [ADDR_W-1:0] ifetch_addr,
    input  logic [BE_W-1:0]   ifetch_byte_enable,
    input  logic              ifetch_read_req,
    output logic [DATA_W-1:0] ifetch_read_data,
    output logic              ifetch_read_data_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [BE_W-1:0]   mem_byte_enable,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    output logic [DATA_W-1:0] mem_read_data,
    output logic              mem_read_data_valid,
    input  logic              system_bus_ready,
    output logic [ADDR_W-1:0] system_bus_addr,
    output logic [BE_W-1:0]   system_bus_byte_enable,
    output logic [DATA_W-1:0] system_bus_write_data,
    output logic              system_bus_read_req,
    output logic              system_bus_write_req,
    input  logic [DATA_W-1:0] system_bus_read_data,
    input  logic              system_bus_read_data_valid
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    requester_t       last_grant_r;
    requester_t       grant_id_s;
    requester_t       head_s;
    logic             if_req_s;
    logic             mem_req_s;
    logic             grant_valid_s;
    logic             grant_is_read_s;
    logic             blocked_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    // Grant selection; fifo fullness alone gates reads so no return strobe reaches any ready.
    always_comb begin
        if_req_s      = ifetch_read_req;
        mem_req_s     = mem_read_req | mem_write_req;
        grant_valid_s = if_req_s | mem_req_s;
        if (if_req_s && mem_req_s) begin
            grant_id_s = (last_grant_r == REQ_MEM) ? REQ_IFETCH : REQ_MEM;
        end else if (mem_req_s) begin
            grant_id_s = REQ_MEM;
        end else begin
            grant_id_s = REQ_IFETCH;
        end
        grant_is_read_s = (grant_id_s == REQ_MEM) ? mem_read_req : if_req_s;
        blocked_s       = grant_is_read_s & fifo_full_s;
        accept_s        = grant_valid_s & system_bus_ready & ~blocked_s;
        push_s          = accept_s & grant_is_read_s;
        pop_s           = system_bus_read_data_valid & ~fifo_empty_s;
    end

    // Request forwarding and return steering.
    always_comb begin
        if (grant_id_s == REQ_MEM) begin
            system_bus_addr        = mem_addr;
            system_bus_byte_enable = mem_byte_enable;
        end else begin
            system_bus_addr        = ifetch_addr;
            system_bus_byte_enable = ifetch_byte_enable;
        end
        system_bus_write_data  = mem_write_data;
        system_bus_read_req    = grant_is_read_s & ~blocked_s;
        system_bus_write_req   = (grant_id_s == REQ_MEM) & mem_write_req;
        ifetch_ready           = grant_valid_s & (grant_id_s == REQ_IFETCH) & system_bus_ready & ~blocked_s;
        mem_ready              = (grant_id_s == REQ_MEM) & system_bus_ready & ~blocked_s;
        ifetch_read_data       = system_bus_read_data;
        mem_read_data          = system_bus_read_data;
        ifetch_read_data_valid = pop_s & (head_s == REQ_IFETCH);
        mem_read_data_valid    = pop_s & (head_s == REQ_MEM);
    end

    // Round-robin history; starting at MEM lets ifetch win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= REQ_MEM;
        end else if (accept_s) begin
            last_grant_r <= grant_id_s;
        end
    end

    read_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .push_id (grant_id_s),
        .pop     (pop_s),
        .head    (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    system_bus_arbiter_checker #(
        .CNT_W (CNT_W)
    ) u_checker (
        .clk             (clk),
        .reset_n         (reset_n),
        .read_data_valid (system_bus_read_data_valid),
        .count           (fifo_count_s)
    );

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Self-checking bench for system_bus_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_system_bus_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ifetch_ready;
    logic [31:0] ifetch_addr;
    logic [3:0]  ifetch_byte_enable;
    logic        ifetch_read_req;
    logic [31:0] ifetch_read_data;
    logic        ifetch_read_data_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        system_bus_ready;
    logic [31:0] system_bus_addr;
    logic [3:0]  system_bus_byte_enable;
    logic [31:0] system_bus_write_data;
    logic        system_bus_read_req;
    logic        system_bus_write_req;
    logic [31:0] system_bus_read_data;
    logic        system_bus_read_data_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state: owners of outstanding reads (1 = mem) and last accepted requester.
    bit q[$];
    bit last_mem;

    system_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .ifetch_ready               (ifetch_ready),
        .ifetch_addr                (ifetch_addr),
        .ifetch_byte_enable         (ifetch_byte_enable),
        .ifetch_read_req            (ifetch_read_req),
        .ifetch_read_data           (ifetch_read_data),
        .ifetch_read_data_valid     (ifetch_read_data_valid),
        .mem_ready                  (mem_ready),
        .mem_addr                   (mem_addr),
        .mem_byte_enable            (mem_byte_enable),
        .mem_write_data             (mem_write_data),
        .mem_read_req               (mem_read_req),
        .mem_write_req              (mem_write_req),
        .mem_read_data              (mem_read_data),
        .mem_read_data_valid        (mem_read_data_valid),
        .system_bus_ready           (system_bus_ready),
        .system_bus_addr            (system_bus_addr),
        .system_bus_byte_enable     (system_bus_byte_enable),
        .system_bus_write_data      (system_bus_write_data),
        .system_bus_read_req        (system_bus_read_req),
        .system_bus_write_req       (system_bus_write_req),
        .system_bus_read_data       (system_bus_read_data),
        .system_bus_read_data_valid (system_bus_read_data_valid)
    );

    always #5 clk = ~clk;

    task automatic idle();
        ifetch_addr = 32'h0; ifetch_byte_enable = 4'h0; ifetch_read_req = 1'b0;
        mem_addr = 32'h0; mem_byte_enable = 4'h0; mem_write_data = 32'h0;
        mem_read_req = 1'b0; mem_write_req = 1'b0;
        system_bus_ready = 1'b0; system_bus_read_data = 32'h0; system_bus_read_data_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        q.delete();
        last_mem = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #3;
        total++; if ({ifetch_ready, mem_ready, system_bus_read_req, system_bus_write_req, ifetch_read_data_valid, mem_read_data_valid} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000000", {ifetch_ready, mem_ready, system_bus_read_req, system_bus_write_req, ifetch_read_data_valid, mem_read_data_valid}); end
        next_cycle();
        reset_n = 1'b1;
        system_bus_ready = 1'b1;
        #3;
        total++; if ({ifetch_ready, mem_ready, system_bus_read_req, system_bus_write_req, ifetch_read_data_valid, mem_read_data_valid} !== 6'b0) begin
            bad++; $display("FAIL idle_ctl got=%b exp=000000", {ifetch_ready, mem_ready, system_bus_read_req, system_bus_write_req, ifetch_read_data_valid, mem_read_data_valid}); end
        next_cycle();
    endtask

    task automatic test_single_read();
        ifetch_read_req = 1'b1; ifetch_addr = 32'h0000_0100; ifetch_byte_enable = 4'hF; system_bus_ready = 1'b1;
        #3;
        total++; if (system_bus_addr !== 32'h100) begin bad++; $display("FAIL t1_addr got=%h exp=%h", system_bus_addr, 32'h100); end
        total++; if (system_bus_read_req !== 1'b1) begin bad++; $display("FAIL t1_rreq got=%b exp=1", system_bus_read_req); end
        total++; if (ifetch_ready !== 1'b1) begin bad++; $display("FAIL t1_if_ready got=%b exp=1", ifetch_ready); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL t1_mem_ready got=%b exp=0", mem_ready); end
        next_cycle();
        ifetch_read_req = 1'b0; system_bus_read_data_valid = 1'b1; system_bus_read_data = 32'hDEAD_BEEF;
        #3;
        total++; if (ifetch_read_data_valid !== 1'b1) begin bad++; $display("FAIL t1_if_valid got=%b exp=1", ifetch_read_data_valid); end
        total++; if (mem_read_data_valid !== 1'b0) begin bad++; $display("FAIL t1_mem_valid got=%b exp=0", mem_read_data_valid); end
        total++; if (ifetch_read_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t1_data got=%h exp=deadbeef", ifetch_read_data); end
        next_cycle();
        idle();
    endtask

    task automatic test_round_robin();
        bit exp_if;
        do_reset();
        ifetch_read_req = 1'b1; mem_read_req = 1'b1; system_bus_ready = 1'b1;
        ifetch_addr = 32'h0000_1000; mem_addr = 32'h0000_2000;
        for (int i = 0; i < 8; i++) begin
            system_bus_read_data_valid = (i > 0);
            system_bus_read_data = $urandom;
            exp_if = (i % 2 == 0);
            #3;
            total++; if (ifetch_ready !== exp_if) begin bad++; $display("FAIL rr_if_ready cyc=%0d got=%b exp=%b", i, ifetch_ready, exp_if); end
            total++; if (mem_ready !== !exp_if) begin bad++; $display("FAIL rr_mem_ready cyc=%0d got=%b exp=%b", i, mem_ready, !exp_if); end
            total++; if (system_bus_addr !== (exp_if ? 32'h1000 : 32'h2000)) begin bad++; $display("FAIL rr_addr cyc=%0d got=%h", i, system_bus_addr); end
            if (i > 0) begin
                total++; if ({ifetch_read_data_valid, mem_read_data_valid} !== {!exp_if, exp_if}) begin
                    bad++; $display("FAIL rr_ret cyc=%0d got=%b exp=%b", i, {ifetch_read_data_valid, mem_read_data_valid}, {!exp_if, exp_if}); end
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_full_and_write();
        do_reset();
        system_bus_ready = 1'b1; ifetch_read_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifetch_addr = 32'h200 + 32'(i * 4);
            #3;
            total++; if (ifetch_ready !== (i < 4)) begin bad++; $display("FAIL fill_ready rd=%0d got=%b exp=%b", i, ifetch_ready, (i < 4)); end
            total++; if (system_bus_read_req !== (i < 4)) begin bad++; $display("FAIL fill_rreq rd=%0d got=%b exp=%b", i, system_bus_read_req, (i < 4)); end
            next_cycle();
        end
        ifetch_read_req = 1'b0; mem_write_req = 1'b1; mem_addr = 32'h300;
        mem_write_data = 32'h55AA_00FF; mem_byte_enable = 4'b0011;
        #3;
        total++; if ({mem_ready, system_bus_write_req, system_bus_read_req} !== 3'b110) begin bad++; $display("FAIL wr_full_ctl got=%b exp=110", {mem_ready, system_bus_write_req, system_bus_read_req}); end
        total++; if (system_bus_write_data !== 32'h55AA_00FF) begin bad++; $display("FAIL wr_data got=%h exp=55aa00ff", system_bus_write_data); end
        total++; if (system_bus_byte_enable !== 4'b0011) begin bad++; $display("FAIL wr_be got=%b exp=0011", system_bus_byte_enable); end
        next_cycle();
        mem_write_req = 1'b0; mem_read_req = 1'b1;
        #3;
        total++; if ({mem_ready, system_bus_read_req} !== 2'b00) begin bad++; $display("FAIL still_full got=%b exp=00", {mem_ready, system_bus_read_req}); end
        next_cycle();
        mem_read_req = 1'b0; ifetch_read_req = 1'b1; system_bus_read_data_valid = 1'b1;
        #3;
        total++; if ({ifetch_ready, ifetch_read_data_valid} !== 2'b01) begin bad++; $display("FAIL pop_at_full got=%b exp=01", {ifetch_ready, ifetch_read_data_valid}); end
        next_cycle();
        system_bus_read_data_valid = 1'b0;
        #3;
        total++; if ({ifetch_ready, system_bus_read_req} !== 2'b11) begin bad++; $display("FAIL after_pop got=%b exp=11", {ifetch_ready, system_bus_read_req}); end
        next_cycle();
        idle();
    endtask

    task automatic test_return_order();
        bit order [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        system_bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifetch_read_req = !order[i]; mem_read_req = order[i];
            system_bus_read_data_valid = (i == 3);
            #3;
            total++; if ({ifetch_ready, mem_ready} !== {!order[i], order[i]}) begin bad++; $display("FAIL ord_issue %0d got=%b", i, {ifetch_ready, mem_ready}); end
            if (i == 3) begin
                total++; if ({ifetch_read_data_valid, mem_read_data_valid} !== 2'b10) begin bad++; $display("FAIL ord_ret 0 got=%b exp=10", {ifetch_read_data_valid, mem_read_data_valid}); end
            end
            next_cycle();
        end
        ifetch_read_req = 1'b0; mem_read_req = 1'b0;
        for (int j = 1; j < 4; j++) begin
            system_bus_read_data_valid = 1'b1;
            #3;
            total++; if ({ifetch_read_data_valid, mem_read_data_valid} !== {!order[j], order[j]}) begin
                bad++; $display("FAIL ord_ret %0d got=%b exp=%b", j, {ifetch_read_data_valid, mem_read_data_valid}, {!order[j], order[j]}); end
            next_cycle();
        end
        system_bus_read_data_valid = 1'b0; ifetch_read_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            total++; if (ifetch_ready !== (i < 4)) begin bad++; $display("FAIL ord_refill rd=%0d got=%b exp=%b", i, ifetch_ready, (i < 4)); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        system_bus_ready = 1'b1; ifetch_read_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            total++; if (ifetch_ready !== 1'b1) begin bad++; $display("FAIL mid_issue %0d got=%b exp=1", i, ifetch_ready); end
            next_cycle();
        end
        ifetch_read_req = 1'b0;
        #2;
        reset_n = 1'b0;
        system_bus_read_data_valid = 1'b1;
        #1;
        total++; if ({ifetch_ready, mem_ready, system_bus_read_req, ifetch_read_data_valid, mem_read_data_valid} !== 5'b0) begin
            bad++; $display("FAIL mid_reset_ctl got=%b exp=00000", {ifetch_ready, mem_ready, system_bus_read_req, ifetch_read_data_valid, mem_read_data_valid}); end
        #2;
        reset_n = 1'b1;
        #1;
        total++; if ({ifetch_read_data_valid, mem_read_data_valid} !== 2'b00) begin bad++; $display("FAIL stray_valid got=%b exp=00", {ifetch_read_data_valid, mem_read_data_valid}); end
        next_cycle();
        system_bus_read_data_valid = 1'b0; ifetch_read_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            total++; if (ifetch_ready !== (i < 4)) begin bad++; $display("FAIL mid_refill rd=%0d got=%b exp=%b", i, ifetch_ready, (i < 4)); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_random();
        bit if_r, mem_r, any, pick_mem, is_rd, stall, ret, head, acc;
        logic [5:0]  exp_ctl;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        int kind;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 2));
            ifetch_read_req = 1'($urandom_range(0, 1));
            mem_read_req = (kind == 1); mem_write_req = (kind == 2);
            ifetch_addr = $urandom; mem_addr = $urandom;
            ifetch_byte_enable = 4'($urandom); mem_byte_enable = 4'($urandom);
            mem_write_data = $urandom; system_bus_read_data = $urandom;
            system_bus_ready = ($urandom_range(0, 3) != 0);
            system_bus_read_data_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            #3;
            if_r = ifetch_read_req; mem_r = mem_read_req | mem_write_req;
            any = if_r | mem_r;
            pick_mem = mem_r && (!if_r || !last_mem);
            is_rd = pick_mem ? mem_read_req : if_r;
            stall = is_rd && (q.size() == MAXO);
            ret = system_bus_read_data_valid && (q.size() > 0);
            head = (q.size() > 0) ? q[0] : 1'b0;
            acc = any && system_bus_ready && !stall;
            exp_ctl = {acc && !pick_mem, acc && pick_mem, is_rd && !stall, pick_mem && mem_write_req, ret && !head, ret && head};
            exp_addr = pick_mem ? mem_addr : ifetch_addr;
            exp_be = pick_mem ? mem_byte_enable : ifetch_byte_enable;
            total++; if ({ifetch_ready, mem_ready, system_bus_read_req, system_bus_write_req, ifetch_read_data_valid, mem_read_data_valid} !== exp_ctl) begin
                bad++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", n, {ifetch_ready, mem_ready, system_bus_read_req, system_bus_write_req, ifetch_read_data_valid, mem_read_data_valid}, exp_ctl); end
            total++; if ({system_bus_addr, system_bus_byte_enable} !== {exp_addr, exp_be}) begin
                bad++; $display("FAIL rnd_addr cyc=%0d got=%h/%h exp=%h/%h", n, system_bus_addr, system_bus_byte_enable, exp_addr, exp_be); end
            total++; if ({system_bus_write_data, mem_read_data, ifetch_read_data} !== {mem_write_data, system_bus_read_data, system_bus_read_data}) begin
                bad++; $display("FAIL rnd_data cyc=%0d wd=%h md=%h id=%h", n, system_bus_write_data, mem_read_data, ifetch_read_data); end
            if (ret) void'(q.pop_front());
            if (acc) begin
                last_mem = pick_mem;
                if (is_rd) q.push_back(pick_mem);
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        q.delete();
        last_mem = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_full_and_write();
        test_return_order();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
